// File: rtl/act_quant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : act_quant                                                       |
// | Brief    : Two-stage valid/ready activation (bypass/ReLU/clipped ReLU/     |
// |            leaky ReLU) and round-half-up requantisation with saturation,   |
// |            DP lanes of signed DW-bit accumulators to signed OW-bit values. |
// | Options  : define ACT_ZCNT_EN to add zcnt_o, the per-beat zero-lane count. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module act_quant #(
  parameter int DW  = 32,
  parameter int DP  = 56,
  parameter int OW  = 8,
  parameter int SHW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DP*DW-1:0]     data_i,
  input  logic [1:0]           mode_i,
  input  logic [DW-1:0]        clip_i,
  input  logic [SHW-1:0]       leak_sh_i,
  input  logic [SHW-1:0]       rq_sh_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DP*OW-1:0]     data_o
`ifdef ACT_ZCNT_EN
  ,
  output logic [$clog2(DP+1)-1:0] zcnt_o
`endif
);

  localparam logic [1:0] c_mode_bypass = 2'd0;
  localparam logic [1:0] c_mode_relu   = 2'd1;
  localparam logic [1:0] c_mode_clip   = 2'd2;
  localparam logic [1:0] c_mode_leaky  = 2'd3;

  // Saturation bounds expressed in the DW+1 bit requant domain.
  localparam logic signed [DW:0] c_ymax = (DW+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [DW:0] c_ymin = (DW+1)'(-(64'sd1 <<< (OW-1)));

  logic                    r_init;
  logic                    r_v1;
  logic                    r_v2;
  logic [DP*DW-1:0]        r_a1;
  logic [SHW-1:0]          r_rq1;
  logic [DP*OW-1:0]        r_y2;
  logic                    w_en1;
  logic                    w_en2;
  logic                    w_acc;
  logic signed [DW-1:0]    w_clip;
  logic [DP*DW-1:0]        w_act;
  logic [DP*OW-1:0]        w_y;
`ifdef ACT_ZCNT_EN
  logic [DP-1:0]           w_zero;
  logic [$clog2(DP+1)-1:0] w_zc;
  logic [$clog2(DP+1)-1:0] r_zc;
`endif

  // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  // ready_o is held low until the first clock after reset release.
  assign w_en2   = !r_v2 || ready_i;
  assign w_en1   = !r_v1 || w_en2;
  assign ready_o = w_en1 && r_init;
  assign w_acc   = valid_i && ready_o;

  // A negative clip ceiling collapses clipped ReLU to all-zero output.
  assign w_clip  = clip_i[DW-1] ? '0 : $signed(clip_i);

  for (genvar i = 0; i < DP; i++) begin : g_lane
    logic signed [DW-1:0] w_x;
    logic signed [DW-1:0] w_a;
    logic signed [DW:0]   w_ae;
    logic signed [DW:0]   w_rnd;
    logic signed [DW:0]   w_r;
    logic [OW-1:0]        w_yl;

    assign w_x = $signed(data_i[i*DW +: DW]);

    // Stage 1 activation on the incoming lane.
    always_comb begin
      case (mode_i)
        c_mode_bypass: w_a = w_x;
        c_mode_relu:   w_a = w_x[DW-1] ? '0 : w_x;
        c_mode_clip:   w_a = w_x[DW-1] ? '0 : ((w_x > w_clip) ? w_clip : w_x);
        c_mode_leaky:  w_a = w_x[DW-1] ? (w_x >>> leak_sh_i) : w_x;
        default:       w_a = w_x;
      endcase
    end

    assign w_act[i*DW +: DW] = w_a;

    // Stage 2 requant: one extra bit absorbs the rounding bias; a zero shift adds no bias.
    always_comb begin
      w_ae  = {r_a1[i*DW+DW-1], r_a1[i*DW +: DW]};
      w_rnd = {{DW{1'b0}}, (r_rq1 != '0)} << (r_rq1 - 1'b1);
      w_r   = (w_ae + w_rnd) >>> r_rq1;
      if (w_r > c_ymax) begin
        w_yl = c_ymax[OW-1:0];
      end else if (w_r < c_ymin) begin
        w_yl = c_ymin[OW-1:0];
      end else begin
        w_yl = w_r[OW-1:0];
      end
    end

    assign w_y[i*OW +: OW] = w_yl;
`ifdef ACT_ZCNT_EN
    assign w_zero[i] = (w_yl == '0);
`endif
  end

  // Marks the first clock after reset release so the input side opens one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init <= 1'b0;
    end else begin
      r_init <= 1'b1;
    end
  end

  // Stage 1 register: activated lanes plus the beat's requant shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_a1  <= '0;
      r_rq1 <= '0;
    end else begin
      if (w_en1) begin
        r_v1 <= w_acc;
      end
      if (w_acc) begin
        r_a1  <= w_act;
        r_rq1 <= rq_sh_i;
      end
    end
  end

  // Stage 2 register: saturated output lanes, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_y2 <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      r_y2 <= w_y;
    end
  end

  assign valid_o = r_v2;
  assign data_o  = r_y2;

`ifdef ACT_ZCNT_EN
  // Population count of zero-valued output lanes for the beat entering stage 2.
  always_comb begin
    w_zc = '0;
    for (int k = 0; k < DP; k++) begin
      w_zc = w_zc + {{($clog2(DP+1)-1){1'b0}}, w_zero[k]};
    end
  end

  // Zero count registered alongside the stage 2 data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zc <= '0;
    end else if (w_en2) begin
      r_zc <= w_zc;
    end
  end

  assign zcnt_o = r_zc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_quant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_act_quant                                                    |
// | Brief    : Randomised self-checking bench for act_quant against an         |
// |            arithmetic reference model (floor division, clamp, saturate).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_act_quant;

  localparam int DW  = 32;
  localparam int DP  = 56;
  localparam int OW  = 8;
  localparam int SHW = 5;
  localparam int ZW  = $clog2(DP+1);

  typedef struct {
    logic [DP*DW-1:0] d;
    logic [1:0]       mode;
    logic [DW-1:0]    clip;
    logic [SHW-1:0]   lsh;
    logic [SHW-1:0]   rsh;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  logic              ready_o;
  logic [DP*DW-1:0]  data_i;
  logic [1:0]        mode_i;
  logic [DW-1:0]     clip_i;
  logic [SHW-1:0]    leak_sh_i;
  logic [SHW-1:0]    rq_sh_i;
  logic              valid_o;
  logic              ready_i;
  logic [DP*OW-1:0]  data_o;
  logic [ZW-1:0]     zcnt_obs;

  int n_chk  = 0;
  int n_fail = 0;

  beat_t            stim[$];
  logic [DP*OW-1:0] got_d[$];
  int               got_z[$];
  int               lat[$];
  int               hold_viol;
  bit               rdy_low;

  act_quant #(.DW(DW), .DP(DP), .OW(OW), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .mode_i    (mode_i),
    .clip_i    (clip_i),
    .leak_sh_i (leak_sh_i),
    .rq_sh_i   (rq_sh_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o)
`ifdef ACT_ZCNT_EN
    ,
    .zcnt_o    (zcnt_obs)
`endif
  );

`ifndef ACT_ZCNT_EN
  assign zcnt_obs = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint model_lane(input longint x, input int mode, input longint clip,
                                        input int lsh, input int rsh);
    longint a, c, r, ymax, ymin;
    ymax = (longint'(1) << (OW-1)) - 1;
    ymin = -(longint'(1) << (OW-1));
    case (mode)
      0: a = x;
      1: a = (x < 0) ? 0 : x;
      2: begin
        c = (clip < 0) ? 0 : clip;
        a = (x < 0) ? 0 : ((x > c) ? c : x);
      end
      default: a = (x < 0) ? fdiv(x, longint'(1) << lsh) : x;
    endcase
    if (rsh == 0) r = a;
    else          r = fdiv(a + (longint'(1) << (rsh-1)), longint'(1) << rsh);
    if (r > ymax) r = ymax;
    if (r < ymin) r = ymin;
    return r;
  endfunction

  function automatic logic [DP*OW-1:0] model_y(input beat_t b);
    logic [DP*OW-1:0] y;
    longint v;
    for (int j = 0; j < DP; j++) begin
      v = model_lane(longint'($signed(b.d[j*DW +: DW])), int'(b.mode),
                     longint'($signed(b.clip)), int'(b.lsh), int'(b.rsh));
      y[j*OW +: OW] = v[OW-1:0];
    end
    return y;
  endfunction

  function automatic int model_zc(input beat_t b);
    logic [DP*OW-1:0] y;
    int n;
    y = model_y(b);
    n = 0;
    for (int j = 0; j < DP; j++) if (y[j*OW +: OW] == '0) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] rand_x();
    case ($urandom_range(0, 3))
      0: return DW'($urandom);
      1: return DW'(int'($urandom_range(0, 600)) - 300);
      2: return {1'b1, {(DW-1){1'b0}}};
      default: return DW'(int'($urandom_range(0, 140000)) - 70000);
    endcase
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int j = 0; j < DP; j++) b.d[j*DW +: DW] = rand_x();
    b.mode = 2'($urandom_range(0, 3));
    b.clip = DW'(int'($urandom_range(0, 450)) - 50);
    b.lsh  = SHW'($urandom_range(0, 31));
    b.rsh  = ($urandom_range(0, 3) == 0) ? SHW'($urandom_range(0, 31)) : SHW'($urandom_range(0, 6));
    return b;
  endfunction

  // ---------------- stream driver / recorder ----------------
  // Presents stim in order and records every emitted beat, its latency and
  // any change of the outputs while the consumer is stalling.
  task automatic run_stream(input int stall_at, input int stall_len, input bit rnd, input int budget);
    int idx, cyc, rem, prev_z;
    bit started, prev_hold;
    logic [DP*OW-1:0] prev_d;
    int acc_cyc[$];
    idx = 0; cyc = 0; rem = 0; started = 0; prev_hold = 0; prev_d = '0; prev_z = 0;
    got_d.delete(); got_z.delete(); lat.delete(); hold_viol = 0; rdy_low = 0;
    while (got_d.size() < stim.size() && cyc < budget) begin
      if (!started && stall_len > 0 && got_d.size() == stall_at && valid_o) begin
        started = 1;
        rem = stall_len;
      end
      ready_i = (rem > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (idx < stim.size() && (!rnd || $urandom_range(0, 4) != 0)) begin
        valid_i   = 1'b1;
        data_i    = stim[idx].d;
        mode_i    = stim[idx].mode;
        clip_i    = stim[idx].clip;
        leak_sh_i = stim[idx].lsh;
        rq_sh_i   = stim[idx].rsh;
      end else begin
        valid_i   = 1'b0;
        data_i    = {DP{32'hdead_beef}};
        mode_i    = 2'($urandom_range(0, 3));
        rq_sh_i   = SHW'($urandom_range(0, 31));
      end
      #1;
      if (prev_hold && (!valid_o || data_o !== prev_d || int'(zcnt_obs) != prev_z)) hold_viol++;
      if (valid_i && !ready_o) rdy_low = 1;
      if (valid_i && ready_o) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (valid_o && ready_i) begin
        got_d.push_back(data_o);
        got_z.push_back(int'(zcnt_obs));
        if (acc_cyc.size() > 0) lat.push_back(cyc - acc_cyc.pop_front());
        else                    lat.push_back(-1);
      end
      prev_hold = valid_o && !ready_i;
      prev_d    = data_o;
      prev_z    = int'(zcnt_obs);
      if (rem > 0) rem--;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    beat_t b;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    data_i = '0; mode_i = '0; clip_i = '0; leak_sh_i = '0; rq_sh_i = '0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (valid_o !== 1'b0 || data_o !== '0 || zcnt_obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: valid_o=%b data_o=%h zcnt=%0d, required 0", valid_o, data_o, zcnt_obs);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_release: ready_o=%b, required 0", ready_o);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: ready_o=%b, required 1", ready_o);
    end
    // Put a beat into the pipe, then reset while it sits at the output.
    valid_i = 1'b1; data_i = {DP{32'd100}}; mode_i = 2'd0; rq_sh_i = '0;
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    n_chk++;
    if (valid_o !== 1'b1 || data_o !== {DP{8'd100}}) begin
      n_fail++; $display("FAIL reset_preload: valid_o=%b data_o=%h, required 1 and lanes 100", valid_o, data_o);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (valid_o !== 1'b0 || data_o !== '0) begin
      n_fail++; $display("FAIL reset_midstream: valid_o=%b data_o=%h, required 0", valid_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (valid_o) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_discard: valid_o seen %0d cycles, required 0", seen);
    end
    @(negedge clk);
    b = rand_beat();
    b.mode = 2'd0; b.rsh = '0;
    stim.delete(); stim.push_back(b);
    run_stream(0, 0, 0, 20);
    n_chk++;
    if (got_d.size() != 1 || lat[0] != 2 || got_d[0] !== model_y(b)) begin
      n_fail++; $display("FAIL reset_first_beat: beats=%0d latency=%0d, required 1 beat at latency 2 matching model",
                         got_d.size(), (lat.size() > 0) ? lat[0] : -1);
    end
  endtask

  task automatic test_modes();
    int expv[4][4] = '{'{-5, 3, 127, -128}, '{0, 3, 127, 0}, '{0, 3, 50, 0}, '{-2, 3, 127, -32}};
    int xin[4] = '{-5, 3, 200, -128};
    logic [DP*OW-1:0] gd;
    logic signed [OW-1:0] lane;
    beat_t b;
    stim.delete();
    for (int m = 0; m < 4; m++) begin
      b = rand_beat();
      for (int j = 0; j < 4; j++) b.d[j*DW +: DW] = DW'(xin[j]);
      b.mode = 2'(m); b.rsh = '0; b.clip = DW'(50); b.lsh = SHW'(2);
      stim.push_back(b);
    end
    run_stream(0, 0, 0, 40);
    n_chk++;
    if (got_d.size() != 4) begin
      n_fail++; $display("FAIL modes_count: %0d beats out, required 4", got_d.size());
    end
    for (int m = 0; m < 4 && m < got_d.size(); m++) begin
      gd = got_d[m];
      n_chk++;
      if (gd !== model_y(stim[m]) || lat[m] != 2) begin
        n_fail++; $display("FAIL modes_beat%0d: data=%h latency=%0d, required data=%h latency 2",
                           m, gd, lat[m], model_y(stim[m]));
      end
      for (int j = 0; j < 4; j++) begin
        lane = gd[j*OW +: OW];
        n_chk++;
        if (int'(lane) != expv[m][j]) begin
          n_fail++; $display("FAIL modes_m%0d_lane%0d: got %0d, required %0d", m, j, lane, expv[m][j]);
        end
      end
    end
  endtask

  task automatic test_requant();
    int xin[4] = '{24, 23, -24, -8};
    int expv[4] = '{2, 1, -1, 0};
    logic [DP*OW-1:0] gd;
    logic signed [OW-1:0] lane;
    beat_t b;
    b = rand_beat();
    for (int j = 0; j < 4; j++) b.d[j*DW +: DW] = DW'(xin[j]);
    b.mode = 2'd0; b.rsh = SHW'(4);
    stim.delete(); stim.push_back(b);
    run_stream(0, 0, 0, 20);
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== model_y(b)) begin
      n_fail++; $display("FAIL requant_beat: beats=%0d, required 1 beat matching model %h", got_d.size(), model_y(b));
    end else begin
      gd = got_d[0];
      for (int j = 0; j < 4; j++) begin
        lane = gd[j*OW +: OW];
        n_chk++;
        if (int'(lane) != expv[j]) begin
          n_fail++; $display("FAIL requant_lane%0d: got %0d, required %0d", j, lane, expv[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    stim.delete();
    for (int k = 0; k < 8; k++) stim.push_back(rand_beat());
    run_stream(3, 5, 0, 200);
    n_chk++;
    if (got_d.size() != 8) begin
      n_fail++; $display("FAIL bp_count: %0d beats out, required 8", got_d.size());
    end
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      n_chk++;
      if (got_d[k] !== model_y(stim[k])) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h, required %h", k, got_d[k], model_y(stim[k]));
      end
    end
    n_chk++;
    if (hold_viol != 0) begin
      n_fail++; $display("FAIL bp_hold: %0d output changes during stall, required 0", hold_viol);
    end
    n_chk++;
    if (rdy_low != 1'b1) begin
      n_fail++; $display("FAIL bp_ready_low: ready_o low observed=%b, required 1", rdy_low);
    end
  endtask

  task automatic test_extremes();
    int expv[3] = '{-1, 127, 0};
    logic [DP*OW-1:0] gd;
    logic signed [OW-1:0] lane;
    beat_t b;
    stim.delete();
    b = rand_beat(); b.d[DW-1:0] = {1'b1, {(DW-1){1'b0}}}; b.mode = 2'd3; b.lsh = SHW'(31); b.rsh = '0;
    stim.push_back(b);
    b = rand_beat(); b.d[DW-1:0] = {1'b0, {(DW-1){1'b1}}}; b.mode = 2'd0; b.rsh = '0;
    stim.push_back(b);
    b = rand_beat(); b.d[DW-1:0] = DW'(1000); b.mode = 2'd2; b.clip = DW'(-7); b.rsh = '0;
    stim.push_back(b);
    run_stream(0, 0, 0, 40);
    n_chk++;
    if (got_d.size() != 3) begin
      n_fail++; $display("FAIL ext_count: %0d beats out, required 3", got_d.size());
    end
    for (int k = 0; k < 3 && k < got_d.size(); k++) begin
      gd = got_d[k];
      lane = gd[OW-1:0];
      n_chk++;
      if (int'(lane) != expv[k] || gd !== model_y(stim[k])) begin
        n_fail++; $display("FAIL ext_case%0d: lane0=%0d data=%h, required lane0=%0d data=%h",
                           k, lane, gd, expv[k], model_y(stim[k]));
      end
    end
  endtask

  task automatic test_random();
    int bad;
    stim.delete();
    for (int k = 0; k < 60; k++) stim.push_back(rand_beat());
    run_stream(0, 0, 1, 3000);
    n_chk++;
    if (got_d.size() != 60) begin
      n_fail++; $display("FAIL rand_count: %0d beats out, required 60", got_d.size());
    end
    for (int k = 0; k < 60 && k < got_d.size(); k++) begin
      n_chk++;
      bad = (got_d[k] !== model_y(stim[k]));
`ifdef ACT_ZCNT_EN
      if (got_z[k] != model_zc(stim[k])) bad = 1;
`endif
      if (bad != 0) begin
        n_fail++; $display("FAIL rand_beat%0d: got %h zc=%0d, required %h zc=%0d",
                           k, got_d[k], got_z[k], model_y(stim[k]), model_zc(stim[k]));
      end
    end
    n_chk++;
    if (hold_viol != 0) begin
      n_fail++; $display("FAIL rand_hold: %0d output changes during stall, required 0", hold_viol);
    end
  endtask

`ifdef ACT_ZCNT_EN
  task automatic test_zcnt();
    beat_t b;
    stim.delete();
    for (int k = 0; k < 2; k++) begin
      b = rand_beat();
      for (int j = 0; j < DP; j++) begin
        if (j < 20) b.d[j*DW +: DW] = DW'(-int'($urandom_range(1, 1000000)));
        else        b.d[j*DW +: DW] = DW'($urandom_range(1, 1000000));
      end
      b.mode = 2'd1; b.rsh = '0;
      stim.push_back(b);
    end
    run_stream(0, 3, 0, 40);
    n_chk++;
    if (got_z.size() != 2 || got_z[0] != 20 || got_z[1] != 20) begin
      n_fail++; $display("FAIL zcnt_value: beats=%0d zcnt=%0d, required 2 beats with zcnt 20",
                         got_z.size(), (got_z.size() > 0) ? got_z[0] : -1);
    end
    n_chk++;
    if (hold_viol != 0) begin
      n_fail++; $display("FAIL zcnt_hold: %0d output changes during stall, required 0", hold_viol);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_requant();
    test_backpressure();
    test_extremes();
    test_random();
`ifdef ACT_ZCNT_EN
    test_zcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
